port_timer: RTL
===============

PORT_TIMER -- requirements
Module: port_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h10, the port_id of register 0; registers occupy BASE_ADDR..BASE_ADDR+6.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port port_id, input, 8, register address from the CPU.
REQ-005 SHALL have port port_in, input, 8, write data from the CPU out_port.
REQ-006 SHALL have port port_out, output, 8, read data to the CPU in_port.
REQ-007 SHALL have port wen, input, 1, write strobe.
REQ-008 SHALL have port ren, input, 1, read strobe.
REQ-009 SHALL have port interrupt, output, 1, level interrupt request to the CPU.
REQ-010 SHALL have port interrupt_ack, input, 1, one-cycle acknowledge from the CPU.

Function
REQ-011 SHALL use register map (offset from BASE_ADDR): 0 CTRL r/w {bit0 EN, bit1 AUTO, bit2 IE}; 1 RLD_LO w; 2 RLD_HI w; 3 CNT_LO r; 4 CNT_HI r; 5 STATUS r/w1c {bit0 EXP}; 6 PRESC r/w.
REQ-012 SHALL register port_out each cycle from the current port_id, so data is valid one cycle after port_id; unmapped addresses return 8'h00.
REQ-013 SHALL hold an RLD_LO write in a shadow register and commit the 16-bit reload only on the RLD_HI write.
REQ-014 SHALL, on a CNT_LO read (ren with port_id = offset 3), snapshot the counter high byte; a later CNT_HI read returns that snapshot.
REQ-015 SHALL implement states IDLE, RUN, DONE: IDLE->RUN when EN is written 1, loading the counter with the reload value; RUN->IDLE when EN is written 0; RUN->DONE on expiry with AUTO=0; DONE->RUN when EN is written 1.
REQ-016 SHALL, in RUN, decrement the counter once per tick; expiry is a tick with counter = 0.
REQ-017 SHALL, on expiry, set EXP; with AUTO=1 reload the counter in the same cycle and stay in RUN; with AUTO=0 clear EN in hardware and enter DONE.
REQ-018 SHALL treat reload = 0 as expiry on every tick.
REQ-019 SHALL drive interrupt = EXP_pending AND IE, where EXP_pending is set on expiry and cleared by interrupt_ack or by writing 1 to STATUS bit0.
REQ-020 SHALL, when an expiry coincides with interrupt_ack or with the STATUS clear, leave EXP and EXP_pending set (set wins).
REQ-021 SHALL, when a reload commit coincides with an expiry, reload from the newly committed value.

Reset
REQ-022 SHALL, on rst low, asynchronously clear CTRL, reload, shadow, counter, snapshot, PRESC, EXP and EXP_pending, enter IDLE, and drive port_out = 8'h00 and interrupt = 0.
REQ-023 SHALL abandon any count in progress on reset mid-operation, with no interrupt after release.

Configuration
REQ-024 SHALL honour macro PORT_TIMER_PRESCALER_EN: when defined, a tick is the cycle when an 8-bit prescale counter, reloaded from PRESC, reaches 0 (period PRESC+1 clocks) and the prescale counter restarts on each IDLE->RUN; when undefined, every clk is a tick, PRESC is not implemented and reads 8'h00.

Structure
REQ-025 SHALL place register offsets, CTRL/STATUS bit positions and state encodings in shared include port_timer_inc.v, alongside the existing _inc.v files.
REQ-026 SHALL implement the port-bus decode and read mux inline; the only sub-module is port_timer_presc (the tick generator), instantiated only when PORT_TIMER_PRESCALER_EN is defined.

Verification
REQ-027 Reset: hold rst low, wiggle all inputs -> port_out = 00 and interrupt = 0 throughout; every register reads 00 after release.
REQ-028 One-shot: write RLD = 0x0003, CTRL = 0x05 -> EXP set and interrupt high exactly 4 ticks later; CTRL reads 0x04 and the state is DONE.
REQ-029 Auto-reload: RLD = 0x0001, CTRL = 0x07 -> expiry every 2 ticks; pulse interrupt_ack -> interrupt low the next cycle and high again at the next expiry.
REQ-030 Coherent read: RLD = 0x0100, running; read CNT_LO while the counter passes 0x0100->0x00FF -> the two bytes form one sampled value (0x0100 or 0x00FF, never 0x01FF or 0x0000).
REQ-031 Simultaneous: STATUS write 0x01 in the same cycle as an expiry -> EXP stays 1 and interrupt stays high.
REQ-032 Prescaler (macro defined): PRESC = 0x03, RLD = 0x0000, CTRL = 0x05 -> first expiry at clock 4 after EN; with the macro undefined the same stimulus gives expiry at clock 1 and PRESC reads 00.

Source files
------------

// File: rtl/port_timer_pkg.sv
// port_timer_pkg: register offsets, CTRL/STATUS bit positions and FSM states for port_timer
package port_timer_pkg;
  localparam logic [7:0] OFF_CTRL   = 8'd0;
  localparam logic [7:0] OFF_RLD_LO = 8'd1;
  localparam logic [7:0] OFF_RLD_HI = 8'd2;
  localparam logic [7:0] OFF_CNT_LO = 8'd3;
  localparam logic [7:0] OFF_CNT_HI = 8'd4;
  localparam logic [7:0] OFF_STATUS = 8'd5;
  localparam logic [7:0] OFF_PRESC  = 8'd6;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IE    = 2;
  localparam int STATUS_EXP = 0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/port_timer_presc.sv
// port_timer_presc: tick generator with period presc+1 clocks, built only with PORT_TIMER_PRESCALER_EN
`ifdef PORT_TIMER_PRESCALER_EN
module port_timer_presc (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [7:0] presc,
  output logic       tick
);
  logic [7:0] pcnt;
  assign tick = pcnt == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) pcnt <= '0;
    else pcnt <= (restart || tick) ? presc : pcnt - 8'd1;
endmodule
`endif

// File: rtl/port_timer.sv
// port_timer: port-mapped 16-bit down-count timer with interrupt; PORT_TIMER_PRESCALER_EN adds a tick prescaler
module port_timer
  import port_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] port_id,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  input  logic       wen,
  input  logic       ren,
  output logic       interrupt,
  input  logic       interrupt_ack
);
  state_t state;
  logic [2:0] ctrl;
  logic [7:0] off, shadow, snap, presc, rdata;
  logic [15:0] rld, rld_next, cnt;
  logic exp, exp_pend, tick, wr_ctrl, commit, w1c, start, expire;
  assign off = port_id - BASE_ADDR;
  assign wr_ctrl = wen && off == OFF_CTRL;
  assign commit = wen && off == OFF_RLD_HI;
  assign w1c = wen && off == OFF_STATUS && port_in[STATUS_EXP];
  assign start = wr_ctrl && port_in[CTRL_EN] && state != RUN;
  assign rld_next = commit ? {port_in, shadow} : rld;
  assign expire = state == RUN && tick && cnt == '0;
  assign interrupt = exp_pend && ctrl[CTRL_IE];
`ifdef PORT_TIMER_PRESCALER_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) presc <= '0;
    else if (wen && off == OFF_PRESC) presc <= port_in;
  port_timer_presc u_presc (.clk(clk), .rst(rst), .restart(start), .presc(presc), .tick(tick));
`else
  assign presc = '0;
  assign tick = 1'b1;
`endif
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata = {5'd0, ctrl};
      OFF_CNT_LO: rdata = cnt[7:0];
      OFF_CNT_HI: rdata = snap;
      OFF_STATUS: rdata = {7'd0, exp};
      OFF_PRESC:  rdata = presc;
      default:    rdata = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ctrl <= '0;
      shadow <= '0;
      rld <= '0;
      cnt <= '0;
      snap <= '0;
      exp <= 1'b0;
      exp_pend <= 1'b0;
      port_out <= '0;
    end else begin
      port_out <= rdata;
      if (wen && off == OFF_RLD_LO) shadow <= port_in;
      if (commit) rld <= rld_next;
      // high byte frozen alongside the low-byte read for a coherent 16-bit sample
      if (ren && off == OFF_CNT_LO) snap <= cnt[15:8];
      if (wr_ctrl) ctrl <= port_in[2:0];
      if (start) begin
        state <= RUN;
        cnt <= rld;
      end else if (wr_ctrl && !port_in[CTRL_EN] && state == RUN) state <= IDLE;
      else if (expire) begin
        if (ctrl[CTRL_AUTO]) cnt <= rld_next;
        else begin
          state <= DONE;
          ctrl[CTRL_EN] <= 1'b0;
        end
      end else if (state == RUN && tick) cnt <= cnt - 16'd1;
      exp <= expire || (exp && !w1c);
      exp_pend <= expire || (exp_pend && !(w1c || interrupt_ack));
    end
endmodule
